// File: rtl/dcache_lsu.sv
// dcache_lsu: load/store initiator for the word-organised data cache.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module dcache_lsu #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              mem_readen_o,
  output logic              mem_writeen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_dato_o,
  input  logic [DATA_W-1:0] mem_dato_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int AW = ADDR_W + 2;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              rd_en, wr_en, mis;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] ext, merged;
  logic              unused_addr;

  // Upper address bits fall outside the cache index and simply wrap.
  assign unused_addr = ^addr_i[31:AW];

  // Alignment / reserved-size check on the incoming request.
  always_comb begin
    mis = 1'b0;
    unique case (size_i)
      2'b00: mis = 1'b0;
      2'b01: mis = addr_i[0];
      2'b10: mis = |addr_i[1:0];
      default: mis = 1'b1;
    endcase
  end

  // Lane extraction with sign/zero extension, and sub-word merge buffer.
  always_comb begin
    lane_b = mem_dato_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_dato_i[{addr_q[1], 4'b0000} +: 16];
    ext    = mem_dato_i;
    merged = mem_dato_i;
    unique case (size_q)
      2'b00: begin
        ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ext    = mem_dato_i;
        merged = mem_dato_i;
      end
    endcase
  end

  // Next-state and cache strobe logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
          addr_d  = addr_i[AW-1:0];
          wdata_d = wdata_i;
          err_d   = mis;
          if (mis)
            state_d = DONE;
          else if (we_i && size_i == 2'b10)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        rd_en = 1'b1;
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = ext;
          state_d = DONE;
        end
      end
      WR: begin
        wr_en   = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced quiet while reset is held so no cache write slips out.
  always_comb begin
    mem_readen_o  = rst_ni & rd_en;
    mem_writeen_o = rst_ni & wr_en;
    mem_addr_o    = (mem_readen_o | mem_writeen_o) ?
                    addr_q[AW-1:2] : '0;
    mem_dato_o    = mem_writeen_o ? wdata_q : '0;
    busy_o        = rst_ni & (state_q != IDLE);
    done_o        = rst_ni & (state_q == DONE);
    err_o         = done_o & err_q;
    rdata_o       = rdata_q;
  end

endmodule

// File: tb/tb_dcache_lsu.sv
// tb_dcache_lsu: directed checks of dcache_lsu against a behavioural cache array.
// Each step drives one request and compares latency, strobes and data.
module tb_dcache_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        done_o, err_o, busy_o;
  logic        mem_readen_o, mem_writeen_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_dato_o, mem_dato_i;

  logic [31:0] mem [1024];

  int vecs = 0;
  int miscompares = 0;

  int          lat, nrd, nwr;
  logic        err;
  logic [9:0]  waddr;
  logic [31:0] wdat;

  dcache_lsu #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
    .err_o(err_o), .busy_o(busy_o), .mem_readen_o(mem_readen_o),
    .mem_writeen_o(mem_writeen_o), .mem_addr_o(mem_addr_o),
    .mem_dato_o(mem_dato_o), .mem_dato_i(mem_dato_i)
  );

  always #5 clk_i = ~clk_i;

  assign mem_dato_i = mem[mem_addr_o];

  always @(posedge clk_i)
    if (mem_writeen_o) mem[mem_addr_o] <= mem_dato_o;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; size_i = sz;
    unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(negedge clk_i);
    req_i = 1'b0;
    lat = 0; nrd = 0; nwr = 0; err = 1'b0;
    waddr = '0; wdat = '0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_readen_o) nrd++;
      if (mem_writeen_o) begin
        nwr++; waddr = mem_addr_o; wdat = mem_dato_o;
      end
      if (done_o) begin
        lat = k; err = err_o;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // reset held with a request pending
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b1; size_i = 2'b10;
    addr_i = 32'h10; wdata_i = 32'h1;
    @(posedge clk_i);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check("rst_en", {30'd0, mem_readen_o, mem_writeen_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_flags", {29'd0, done_o, err_o, busy_o}, 32'd0);
    end
    rst_ni = 1'b1; req_i = 1'b0;

    // word store then word load
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_acc", {nrd[15:0], nwr[15:0]}, {16'd0, 16'd1});
    check("sw_addr", {22'd0, waddr}, 32'd4);
    check("sw_data", wdat, 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_lat", lat, 2);
    check("lw_acc", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd0});
    check("lw_data", rdata_o, 32'hDEADBEEF);

    // byte store read-modify-write
    txn(1'b1, 2'b00, 1'b0, 32'h12, 32'hAAAAAA55);
    check("sb_lat", lat, 3);
    check("sb_acc", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
    check("sb_addr", {22'd0, waddr}, 32'd4);
    check("sb_data", wdat, 32'hDE55BEEF);
    check("sb_rdata_kept", rdata_o, 32'hDEADBEEF);

    // load extension
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_s", rdata_o, 32'hFFFFFFDE);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_u", rdata_o, 32'h000000DE);
    txn(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    check("lb_pos", rdata_o, 32'h00000055);
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lh_u_hi", rdata_o, 32'h0000DE55);
    txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lh_s", rdata_o, 32'hFFFFBEEF);
    check("lh_lat", lat, 2);

    // error cases: one cycle, no cache access, rdata kept
    txn(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234);
    check("e_sh_lat", lat, 1);
    check("e_sh_err", {31'd0, err}, 32'd1);
    check("e_sh_acc", nrd + nwr, 0);
    @(negedge clk_i);
    check("e_err_clr", {30'd0, done_o, err_o}, 32'd0);
    txn(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    check("e_lw_lat", lat, 1);
    check("e_lw_err", {31'd0, err}, 32'd1);
    check("e_lw_acc", nrd + nwr, 0);
    txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("e_rsv_lat", lat, 1);
    check("e_rsv_err", {31'd0, err}, 32'd1);
    check("e_rdata_kept", rdata_o, 32'hFFFFBEEF);

    // index wraps above the cache address range
    txn(1'b0, 2'b10, 1'b0, 32'h1010, 32'h0);
    check("wrap_data", rdata_o, 32'hDE55BEEF);
    check("wrap_err", {31'd0, err}, 32'd0);

    // reset during WR of a byte store aborts the write
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00;
    unsigned_i = 1'b0; addr_i = 32'h12; wdata_i = 32'h77;
    @(negedge clk_i);
    req_i = 1'b0;
    check("ab_rd", {31'd0, mem_readen_o}, 32'd1);
    @(negedge clk_i);
    check("ab_wr_pre", {31'd0, mem_writeen_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("ab_wr_gated", {31'd0, mem_writeen_o}, 32'd0);
    check("ab_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    check("ab_done", {30'd0, done_o, busy_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("ab_idle", {30'd0, done_o, busy_o}, 32'd0);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("ab_mem", rdata_o, 32'hDE55BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
